// File: rtl/controle_spawn_aste.sv
// Spawn scheduler: walks the spawn ROM and offers one entry per period over valid/ready.
// Optional SPAWN_ALEATORIO_EN selects the next entry from an 8-bit LFSR; timing is the same in both builds.
module controle_spawn_aste #(
  parameter int PERIODO    = 1000,
  parameter int N_ENTRADAS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       parar,
  output logic [3:0] rom_addr,
  input  logic [9:0] rom_q,
  output logic       spawn_valid,
  input  logic       spawn_ready,
  output logic [3:0] spawn_x,
  output logic [3:0] spawn_y,
  output logic [1:0] spawn_dir,
  output logic       ativo
);

  typedef enum logic [2:0] {OCIOSO, LE, CAPTURA, OFERECE, ESPERA} estado_t;

  localparam logic [3:0]  ULTIMO  = 4'(N_ENTRADAS - 1);
  localparam logic [15:0] RECARGA = 16'(PERIODO - 1);

  estado_t     estado, estado_prox;
  logic [3:0]  indice, indice_prox;
  logic [15:0] contador, contador_prox;
  logic        valid_prox;
  logic [3:0]  x_prox, y_prox;
  logic [1:0]  dir_prox;
  logic [3:0]  seq_prox;
  logic [3:0]  avanco;
  logic        aceite;

  assign seq_prox = (indice == ULTIMO) ? 4'd0 : indice + 4'd1;
  // A stop on the same edge as a handshake discards the handshake.
  assign aceite   = (estado == OFERECE) && spawn_ready && !parar;

`ifdef SPAWN_ALEATORIO_EN
  logic [7:0] lfsr;

  always_comb begin
    avanco = seq_prox;
    if (int'(lfsr[3:0]) < N_ENTRADAS) avanco = lfsr[3:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       lfsr <= 8'h01;
    else if (aceite) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
`else
  assign avanco = seq_prox;
`endif

  always_comb begin
    estado_prox   = estado;
    indice_prox   = indice;
    contador_prox = contador;
    valid_prox    = spawn_valid;
    x_prox        = spawn_x;
    y_prox        = spawn_y;
    dir_prox      = spawn_dir;
    if (parar) begin
      estado_prox   = OCIOSO;
      valid_prox    = 1'b0;
      contador_prox = 16'd0;
    end else begin
      case (estado)
        OCIOSO:  if (iniciar) estado_prox = LE;
        LE:      estado_prox = CAPTURA;
        CAPTURA: begin
          x_prox      = rom_q[9:6];
          y_prox      = rom_q[5:2];
          dir_prox    = rom_q[1:0];
          valid_prox  = 1'b1;
          estado_prox = OFERECE;
        end
        OFERECE: if (spawn_ready) begin
          valid_prox    = 1'b0;
          indice_prox   = avanco;
          contador_prox = RECARGA;
          estado_prox   = ESPERA;
        end
        ESPERA: begin
          if (contador == 16'd0) estado_prox = LE;
          else                   contador_prox = contador - 16'd1;
        end
        default: estado_prox = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado      <= OCIOSO;
      indice      <= 4'd0;
      contador    <= 16'd0;
      spawn_valid <= 1'b0;
      spawn_x     <= 4'd0;
      spawn_y     <= 4'd0;
      spawn_dir   <= 2'd0;
    end else begin
      estado      <= estado_prox;
      indice      <= indice_prox;
      contador    <= contador_prox;
      spawn_valid <= valid_prox;
      spawn_x     <= x_prox;
      spawn_y     <= y_prox;
      spawn_dir   <= dir_prox;
    end
  end

  assign rom_addr = indice;
  assign ativo    = (estado != OCIOSO);

endmodule

// File: tb/tb_controle_spawn_aste.sv
// Directed bench for controle_spawn_aste with a registered-address ROM model (PERIODO=4).
module tb_controle_spawn_aste;

  logic       clk = 1'b0;
  logic       reset, iniciar, parar, spawn_ready;
  logic [3:0] rom_addr, rom_addr3, ra, ra3;
  logic [9:0] rom_q, rom_q3;
  logic       spawn_valid, spawn_valid3, ativo, ativo3;
  logic [3:0] spawn_x, spawn_y, spawn_x3, spawn_y3;
  logic [1:0] spawn_dir, spawn_dir3;
  logic [9:0] rom_mem [16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ra  <= rom_addr;
    ra3 <= rom_addr3;
  end
  assign rom_q  = rom_mem[ra];
  assign rom_q3 = rom_mem[ra3];

  controle_spawn_aste #(.PERIODO(4), .N_ENTRADAS(4)) dut (
    .clk(clk), .reset(reset), .iniciar(iniciar), .parar(parar),
    .rom_addr(rom_addr), .rom_q(rom_q), .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dir(spawn_dir), .ativo(ativo));

  controle_spawn_aste #(.PERIODO(4), .N_ENTRADAS(3)) dut3 (
    .clk(clk), .reset(reset), .iniciar(iniciar), .parar(parar),
    .rom_addr(rom_addr3), .rom_q(rom_q3), .spawn_valid(spawn_valid3), .spawn_ready(spawn_ready),
    .spawn_x(spawn_x3), .spawn_y(spawn_y3), .spawn_dir(spawn_dir3), .ativo(ativo3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit use3, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(use3 ? spawn_valid3 : spawn_valid) && n < 20);
  endtask

  task automatic do_reset();
    reset = 1'b1; iniciar = 1'b0; parar = 1'b0; spawn_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic pulse_iniciar();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; iniciar = 1'b0; parar = 1'b0; spawn_ready = 1'b0;
    #1;
    checks++;
    if ({spawn_valid, ativo, rom_addr, spawn_x, spawn_y, spawn_dir} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got %0h want 0", {spawn_valid, ativo, rom_addr, spawn_x, spawn_y, spawn_dir});
    end
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (ativo !== 1'b0 || spawn_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got ativo=%b valid=%b want 0 0", ativo, spawn_valid);
    end
  endtask

  task automatic test_sequence();
    int n;
    logic [3:0] exp_idx;
    logic [7:0] lf;
    do_reset();
    spawn_ready = 1'b1;
    exp_idx = 4'd0;
    lf = 8'h01;
    pulse_iniciar();
    for (int k = 0; k < 8; k++) begin
      wait_valid(1'b0, n);
      checks++;
      if (n !== ((k == 0) ? 2 : 7)) begin
        errors++;
        $display("FAIL seq_spacing[%0d] got %0d want %0d", k, n, (k == 0) ? 2 : 7);
      end
      checks++;
      if (rom_addr !== exp_idx) begin
        errors++;
        $display("FAIL seq_addr[%0d] got %0d want %0d", k, rom_addr, exp_idx);
      end
      checks++;
      if ({spawn_x, spawn_y, spawn_dir} !== rom_mem[exp_idx]) begin
        errors++;
        $display("FAIL seq_data[%0d] got %0h want %0h", k, {spawn_x, spawn_y, spawn_dir}, rom_mem[exp_idx]);
      end
`ifdef SPAWN_ALEATORIO_EN
      if (lf[3:0] < 4'd4) exp_idx = lf[3:0];
      else                exp_idx = (exp_idx == 4'd3) ? 4'd0 : exp_idx + 4'd1;
      lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
`else
      exp_idx = (exp_idx == 4'd3) ? 4'd0 : exp_idx + 4'd1;
`endif
    end
    tick();
    checks++;
    if (spawn_valid !== 1'b0) begin
      errors++;
      $display("FAIL seq_pulse_width got %b want 0", spawn_valid);
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    pulse_iniciar();
    wait_valid(1'b0, n);
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (spawn_valid !== 1'b1 || {spawn_x, spawn_y, spawn_dir} !== rom_mem[0]) begin
        errors++;
        $display("FAIL hold[%0d] got valid=%b data=%0h want 1 %0h", c, spawn_valid, {spawn_x, spawn_y, spawn_dir}, rom_mem[0]);
      end
    end
    spawn_ready = 1'b1;
    tick();
    spawn_ready = 1'b0;
    checks++;
    if (spawn_valid !== 1'b0) begin
      errors++;
      $display("FAIL accept_drop got %b want 0", spawn_valid);
    end
    wait_valid(1'b0, n);
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL accept_to_valid got %0d want 6", n);
    end
    checks++;
    if ({spawn_x, spawn_y, spawn_dir} !== rom_mem[1]) begin
      errors++;
      $display("FAIL bp_next_data got %0h want %0h", {spawn_x, spawn_y, spawn_dir}, rom_mem[1]);
    end
  endtask

  task automatic test_parar();
    int n;
    do_reset();
    spawn_ready = 1'b1;
    pulse_iniciar();
    wait_valid(1'b0, n);
    wait_valid(1'b0, n);
    tick();
    parar = 1'b1;
    tick();
    parar = 1'b0;
    checks++;
    if (ativo !== 1'b0 || spawn_valid !== 1'b0 || rom_addr !== 4'd2) begin
      errors++;
      $display("FAIL parar_stop got ativo=%b valid=%b addr=%0d want 0 0 2", ativo, spawn_valid, rom_addr);
    end
    iniciar = 1'b1; parar = 1'b1;
    tick();
    iniciar = 1'b0; parar = 1'b0;
    tick();
    checks++;
    if (ativo !== 1'b0) begin
      errors++;
      $display("FAIL parar_wins got ativo=%b want 0", ativo);
    end
    pulse_iniciar();
    wait_valid(1'b0, n);
    checks++;
    if (n !== 2 || {spawn_x, spawn_y, spawn_dir} !== 10'b0111_0000_10) begin
      errors++;
      $display("FAIL restart_entry got n=%0d data=%0h want 2 %0h", n, {spawn_x, spawn_y, spawn_dir}, 10'b0111_0000_10);
    end
  endtask

  task automatic test_n3();
    int n;
    logic [3:0] seq3 [4];
    seq3[0] = 4'd0; seq3[1] = 4'd1; seq3[2] = 4'd2; seq3[3] = 4'd0;
    do_reset();
    spawn_ready = 1'b1;
    pulse_iniciar();
    for (int k = 0; k < 4; k++) begin
      wait_valid(1'b1, n);
      checks++;
      if (rom_addr3 !== seq3[k] || {spawn_x3, spawn_y3, spawn_dir3} !== rom_mem[seq3[k]]) begin
        errors++;
        $display("FAIL n3_entry[%0d] got addr=%0d data=%0h want %0d %0h", k, rom_addr3, {spawn_x3, spawn_y3, spawn_dir3}, seq3[k], rom_mem[seq3[k]]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    pulse_iniciar();
    wait_valid(1'b0, n);
    spawn_ready = 1'b1;
    tick();
    spawn_ready = 1'b0;
    wait_valid(1'b0, n);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({spawn_valid, ativo, rom_addr, spawn_x, spawn_y, spawn_dir} !== 15'd0) begin
      errors++;
      $display("FAIL reset_mid got %0h want 0", {spawn_valid, ativo, rom_addr, spawn_x, spawn_y, spawn_dir});
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom_mem[i] = {i[3:0], ~i[3:0], 2'b00};
    rom_mem[0] = 10'b0000_0111_00;
    rom_mem[1] = 10'b1110_0111_01;
    rom_mem[2] = 10'b0111_0000_10;
    rom_mem[3] = 10'b0111_1110_11;
    test_reset();
    test_sequence();
    test_backpressure();
    test_parar();
    test_n3();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
